// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main sequencer for the multicycle RV32I datapath
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;
  state_t state_q, state_d;
  logic pc_update, branch;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  assign state  = state_q;
  assign ImmSrc = op == OP_SW  ? 2'b01 :
                  op == OP_BEQ ? 2'b10 :
                  op == OP_JAL ? 2'b11 : 2'b00;
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jump target
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        state_d    = (op == OP_LW || op == OP_SW) ? MEMADR :
                     op == OP_R   ? EXECUTER :
                     op == OP_I   ? EXECUTEI :
                     op == OP_BEQ ? BEQ :
                     op == OP_JAL ? JAL : FETCH;
        illegal_op = state_d == FETCH;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op == OP_LW ? MEMREAD : op == OP_SW ? MEMWRITE : FETCH;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b01;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b11;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase
    PCWrite = pc_update | (branch & zero);
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed vector table plus async-reset sequence
module tb_multicycle_control_fsm;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, IL = 7'b0000000;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb, aop;
    logic rw;
    logic [1:0] imm;
    logic dn, ill;
  } outs_t;
  typedef struct {
    logic r;
    logic [6:0] o;
    logic z, m;
    outs_t e;
  } vec_t;
  logic clk = 0, rst = 1, zero = 0, mem_ready = 1;
  logic [6:0] op = 7'b0110011;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state;
  outs_t got;
  int checks = 0, fails = 0;
  vec_t q[$];
  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  assign got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUOp, RegWrite, ImmSrc, instr_done, illegal_op};
  function automatic vec_t mk(input logic r, input logic [6:0] o, input logic z, m,
      input logic [3:0] st, input logic pcw, adr, mw, irw,
      input logic [1:0] rs, sa, sb, aop, input logic rw, input logic [1:0] imm,
      input logic dn, ill);
    vec_t v;
    v.r = r; v.o = o; v.z = z; v.m = m;
    v.e = {st, pcw, adr, mw, irw, rs, sa, sb, aop, rw, imm, dn, ill};
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  initial begin
    //                r  op z  m  st pcw adr mw irw rs sa sb aop rw imm dn ill
    q.push_back(mk(1, RT, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(0, RT, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(0, RT, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, RT, 0, 1, 6, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
    q.push_back(mk(0, RT, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(0, IT, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(0, IT, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, IT, 0, 1, 7, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
    q.push_back(mk(0, IT, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(0, LW, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, LW, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(0, LW, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, LW, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, LW, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, LW, 0, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(0, SW, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    q.push_back(mk(0, BQ, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 2, 0, 0));
    q.push_back(mk(0, BQ, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0));
    q.push_back(mk(0, BQ, 1, 1, 9, 1, 0, 0, 0, 0, 2, 0, 3, 0, 2, 1, 0));
    q.push_back(mk(0, BQ, 1, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 2, 0, 0));
    q.push_back(mk(0, BQ, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0));
    q.push_back(mk(0, BQ, 0, 1, 9, 0, 0, 0, 0, 0, 2, 0, 3, 0, 2, 1, 0));
    q.push_back(mk(0, JL, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 3, 0, 0));
    q.push_back(mk(0, JL, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 0, 0));
    q.push_back(mk(0, JL, 0, 1, 10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 0, 0));
    q.push_back(mk(0, JL, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
    q.push_back(mk(0, IL, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0));
    q.push_back(mk(0, IL, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    q.push_back(mk(0, SW, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(0, SW, 0, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    q.push_back(mk(0, SW, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 1, 0, 0));
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst = q[i].r; op = q[i].o; zero = q[i].z; mem_ready = q[i].m;
      #1 chk($sformatf("vec%0d", i), 32'(got), 32'(q[i].e));
    end
    // store in flight when reset hits between edges
    @(negedge clk);
    #1 chk("hs_decode", 32'(state), 32'd1);
    @(negedge clk);
    #1 chk("hs_memadr", 32'(state), 32'd2);
    @(negedge clk);
    mem_ready = 0;
    #1 chk("hs_memwrite_state", 32'(state), 32'd5);
    chk("hs_memwrite_mw", 32'(MemWrite), 32'd1);
    #2 rst = 1;
    #1 chk("rst_mw", 32'(MemWrite), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rw", 32'(RegWrite), 32'd0);
    chk("rst_irw", 32'(IRWrite), 32'd0);
    chk("rst_srcb", 32'(ALUSrcB), 32'd2);
    @(negedge clk);
    rst = 0; mem_ready = 1; op = RT;
    #1 chk("post_fetch_state", 32'(state), 32'd0);
    chk("post_fetch_irw", 32'(IRWrite), 32'd1);
    @(negedge clk);
    #1 chk("post_decode", 32'(state), 32'd1);
    @(negedge clk);
    #1 chk("post_exec", 32'(state), 32'd6);
    @(negedge clk);
    #1 chk("post_aluwb_done", 32'(instr_done), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
